phy_rx: RTL and testbench

USB 2.0 full-speed receiver physical layer (USB2.0 Chap. 7), the receive-side counterpart of the PHY transmitter. It sits between the USB bus differential receivers and the SIE. It performs:
- bit-clock recovery
- NRZI decoding
- SYNC detection
- bit-unstuffing
- EOP detection
- bus-reset detection

Received bits are assembled into 8-bit bytes and presented to the SIE.

---
 rtl/phy_rx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_phy_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx.sv
// phy_rx: USB 2.0 full-speed receive PHY.
//
// Recovers the bit clock from line transitions, decodes NRZI, finds SYNC,
// removes stuffed bits, detects EOP and bus reset, and hands bytes to the SIE.
//
// Ports:
//   clk_i        clock, 12 MHz * BIT_SAMPLES
//   rstn_i       asynchronous active-low reset
//   dp_rx_i      D+ from the bus receiver (asynchronous)
//   dn_rx_i      D- from the bus receiver (asynchronous)
//   rx_en_i      reception enable, low while the transmitter owns the bus
//   rx_data_o    last received byte (LSB first on the wire)
//   rx_valid_o   one-cycle pulse, rx_data_o holds a new byte
//   rx_ready_o   packet in progress, from SYNC accepted to EOP/abort
//   rx_err_o     one-cycle pulse on a packet error (at most one per packet)
//   bus_reset_o  bus reset detected (SE0 held for RESET_BITS bit times)

module phy_rx #(
    parameter int unsigned BIT_SAMPLES = 4,
    parameter int unsigned RESET_BITS  = 30
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       dp_rx_i,
    input  logic       dn_rx_i,
    input  logic       rx_en_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_ready_o,
    output logic       rx_err_o,
    output logic       bus_reset_o
);

    localparam int unsigned CNT_W = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] SAMPLE_PHASE = CNT_W'(BIT_SAMPLES / 2);
    localparam logic [CNT_W-1:0] LAST_PHASE   = CNT_W'(BIT_SAMPLES - 1);

    localparam int unsigned RST_W = $clog2(RESET_BITS + 1);
    localparam logic [RST_W-1:0] RESET_LIMIT = RST_W'(RESET_BITS);
    localparam logic [RST_W-1:0] RESET_LAST  = RST_W'(RESET_BITS - 1);

    // Line states as {dp, dn}
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (reset to J so reset release causes no edge)
    // ------------------------------------------------------------------
    logic dp_meta, dp_sync, dn_meta, dn_sync;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dn_meta <= 1'b0;
            dn_sync <= 1'b0;
        end else begin
            dp_meta <= dp_rx_i;
            dp_sync <= dp_meta;
            dn_meta <= dn_rx_i;
            dn_sync <= dn_meta;
        end
    end

    logic [1:0] line;
    logic [1:0] line_last;
    logic       line_edge;

    assign line      = {dp_sync, dn_sync};
    assign line_edge = (line != line_last);

    // ------------------------------------------------------------------
    // Clock recovery. The cycle in which a new line state first appears is
    // phase 0, so the sample lands BIT_SAMPLES/2 cycles into the bit and
    // bits shortened to BIT_SAMPLES-1 cycles are still caught.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phase_now;
    logic             sample;

    always_comb begin
        phase_now = line_edge ? '0 : phase;
        sample    = (phase_now == SAMPLE_PHASE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            line_last <= LINE_J;
            phase     <= '0;
        end else begin
            line_last <= line;
            if (phase_now == LAST_PHASE) begin
                phase <= '0;
            end else begin
                phase <= phase_now + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine, NRZI decode, unstuffing, bus-reset detection
    // ------------------------------------------------------------------
    state_t           state;
    logic [1:0]       prev_line;
    logic [1:0]       zero_cnt;
    logic [2:0]       ones_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             err_seen;
    logic             se0_seen;
    logic [2:0]       j_cnt;
    logic [RST_W-1:0] se0_cnt;

    logic nrzi_bit;
    logic line_se;
    logic reset_hit;

    always_comb begin
        nrzi_bit  = (line == prev_line);
        line_se   = (line == LINE_SE0) || (line == LINE_SE1);
        // This sample completes (or extends) a bus-reset length SE0
        reset_hit = sample && (line == LINE_SE0) && (se0_cnt >= RESET_LAST);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            prev_line   <= LINE_J;
            zero_cnt    <= '0;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            err_seen    <= 1'b0;
            se0_seen    <= 1'b0;
            j_cnt       <= '0;
            se0_cnt     <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            rx_ready_o  <= 1'b0;
            rx_err_o    <= 1'b0;
            bus_reset_o <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;

            if (sample) begin
                prev_line <= line;
                if (line == LINE_SE0) begin
                    if (se0_cnt != RESET_LIMIT) begin
                        se0_cnt <= se0_cnt + 1'b1;
                    end
                    if (se0_cnt >= RESET_LAST) begin
                        bus_reset_o <= 1'b1;
                    end
                end else begin
                    se0_cnt     <= '0;
                    bus_reset_o <= 1'b0;
                end
            end

            if (!rx_en_i || reset_hit) begin
                // Transmitter owns the bus, or a bus reset kills the packet
                state      <= ST_IDLE;
                rx_ready_o <= 1'b0;
            end else if (sample) begin
                case (state)
                    ST_IDLE: begin
                        if (line == LINE_K) begin
                            // First K of SYNC is a transition from idle J: a 0
                            state    <= ST_SYNC;
                            zero_cnt <= 2'd1;
                        end
                    end

                    ST_SYNC: begin
                        if (line_se) begin
                            state <= ST_IDLE;
                        end else if (!nrzi_bit) begin
                            if (zero_cnt != 2'd3) begin
                                zero_cnt <= zero_cnt + 1'b1;
                            end
                        end else if (zero_cnt == 2'd3) begin
                            state      <= ST_DATA;
                            rx_ready_o <= 1'b1;
                            bit_cnt    <= '0;
                            // The closing 1 of SYNC counts toward stuffing
                            ones_cnt   <= 3'd1;
                            err_seen   <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end

                    ST_DATA: begin
                        if (line == LINE_SE0) begin
                            state <= ST_EOP;
                            if (bit_cnt != 3'd0) begin
                                rx_err_o <= ~err_seen;
                                err_seen <= 1'b1;
                            end
                        end else if (line == LINE_SE1) begin
                            rx_err_o   <= ~err_seen;
                            err_seen   <= 1'b1;
                            state      <= ST_ABORT;
                            rx_ready_o <= 1'b0;
                            se0_seen   <= 1'b0;
                            j_cnt      <= '0;
                        end else if (ones_cnt == 3'd6) begin
                            // Stuff position: must be a 0, which is dropped
                            if (nrzi_bit) begin
                                rx_err_o   <= ~err_seen;
                                err_seen   <= 1'b1;
                                state      <= ST_ABORT;
                                rx_ready_o <= 1'b0;
                                se0_seen   <= 1'b0;
                                j_cnt      <= '0;
                            end else begin
                                ones_cnt <= '0;
                            end
                        end else begin
                            ones_cnt <= nrzi_bit ? ones_cnt + 1'b1 : 3'd0;
                            shift    <= {nrzi_bit, shift[7:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                rx_data_o  <= {nrzi_bit, shift[7:1]};
                                rx_valid_o <= 1'b1;
                            end
                        end
                    end

                    ST_EOP: begin
                        if (line == LINE_J) begin
                            state      <= ST_IDLE;
                            rx_ready_o <= 1'b0;
                        end else if (line == LINE_K) begin
                            rx_err_o   <= ~err_seen;
                            err_seen   <= 1'b1;
                            state      <= ST_ABORT;
                            rx_ready_o <= 1'b0;
                            se0_seen   <= 1'b0;
                            j_cnt      <= '0;
                        end
                    end

                    ST_ABORT: begin
                        rx_ready_o <= 1'b0;
                        if (line_se) begin
                            se0_seen <= 1'b1;
                            j_cnt    <= '0;
                        end else if (line == LINE_J) begin
                            if (se0_seen || (j_cnt == 3'd7)) begin
                                state <= ST_IDLE;
                            end else begin
                                j_cnt <= j_cnt + 1'b1;
                            end
                        end else begin
                            se0_seen <= 1'b0;
                            j_cnt    <= '0;
                        end
                    end

                    default: begin
                        state      <= ST_IDLE;
                        rx_ready_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx: directed self-checking bench for phy_rx (BIT_SAMPLES=4).
// A small NRZI/bit-stuffing transmitter drives D+/D-; a monitor counts
// rx_valid_o / rx_err_o pulses and records received bytes.

module tb_phy_rx;

    localparam int BS = 4;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] J   = 2'b10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       dp = 1'b1;
    logic       dn = 1'b0;
    logic       rx_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_err;
    logic       bus_reset;

    always #10 clk = ~clk;

    phy_rx #(
        .BIT_SAMPLES(BS),
        .RESET_BITS (30)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .dp_rx_i    (dp),
        .dn_rx_i    (dn),
        .rx_en_i    (rx_en),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_o (rx_ready),
        .rx_err_o   (rx_err),
        .bus_reset_o(bus_reset)
    );

    int checks = 0;
    int failures = 0;

    // Pulse monitor
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] bytes [64];

    always @(posedge clk) begin
        if (rx_valid) begin
            bytes[valid_cnt[5:0]] <= rx_data;
            valid_cnt <= valid_cnt + 1;
        end
        if (rx_err) err_cnt <= err_cnt + 1;
        if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model
    bit lvl = 1'b1;   // 1 = J, 0 = K
    int ones = 0;
    bit jitter = 1'b0;
    bit jit_phase = 1'b0;

    task automatic hold(input logic [1:0] st);
        int p;
        {dp, dn} = st;
        if (jitter) begin
            p = jit_phase ? 3 : 5;
            jit_phase = ~jit_phase;
        end else begin
            p = BS;
        end
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic nrzi(input bit b);
        if (!b) lvl = ~lvl;
        hold(lvl ? J : K);
    endtask

    task automatic send_bit(input bit b, input bit stuff_en);
        nrzi(b);
        if (b) ones++;
        else ones = 0;
        if (stuff_en && ones == 6) begin
            nrzi(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_sync();
        lvl  = 1'b1;
        ones = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
    endtask

    task automatic send_bits(input logic [7:0] v, input int first, input int last,
                             input bit stuff_en);
        for (int i = first; i <= last; i++) send_bit(v[i], stuff_en);
    endtask

    task automatic send_eop();
        hold(SE0);
        hold(SE0);
        hold(J);
        lvl = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) hold(J);
        lvl = 1'b1;
    endtask

    int base_v;
    int base_e;

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_ready", rx_ready, 1'b0);
        check("reset_err", rx_err, 1'b0);
        check("reset_bus_reset", bus_reset, 1'b0);
        rstn = 1'b1;
        idle(4);

        // 1: two plain bytes
        base_v = valid_cnt;
        base_e = err_cnt;
        send_sync();
        send_bits(8'hA5, 0, 7, 1'b1);
        check("t1_ready_in_packet", rx_ready, 1'b1);
        send_bits(8'h5A, 0, 7, 1'b1);
        send_eop();
        idle(4);
        check("t1_valid_count", valid_cnt - base_v, 2);
        check("t1_byte0", bytes[base_v[5:0]], 8'hA5);
        check("t1_byte1", bytes[(base_v + 1) & 63], 8'h5A);
        check("t1_data_hold", rx_data, 8'h5A);
        check("t1_ready_after_eop", rx_ready, 1'b0);
        check("t1_err_count", err_cnt - base_e, 0);

        // 2: stuffed bit inside 0xFF
        base_v = valid_cnt;
        base_e = err_cnt;
        send_sync();
        send_bits(8'hFF, 0, 7, 1'b1);
        send_bits(8'h01, 0, 7, 1'b1);
        send_eop();
        idle(4);
        check("t2_valid_count", valid_cnt - base_v, 2);
        check("t2_byte0", bytes[base_v[5:0]], 8'hFF);
        check("t2_byte1", bytes[(base_v + 1) & 63], 8'h01);
        check("t2_err_count", err_cnt - base_e, 0);

        // 3: seven ones without a stuff bit
        base_v = valid_cnt;
        base_e = err_cnt;
        send_sync();
        send_bits(8'hFF, 0, 7, 1'b0);
        check("t3_ready_after_err", rx_ready, 1'b0);
        send_bits(8'hFF, 0, 3, 1'b0);
        send_eop();
        idle(4);
        check("t3_err_count", err_cnt - base_e, 1);
        check("t3_valid_count", valid_cnt - base_v, 0);

        // 4: SE0 after half a byte
        base_v = valid_cnt;
        base_e = err_cnt;
        send_sync();
        send_bits(8'hA5, 0, 3, 1'b1);
        check("t4_ready_in_packet", rx_ready, 1'b1);
        send_eop();
        idle(4);
        check("t4_err_count", err_cnt - base_e, 1);
        check("t4_valid_count", valid_cnt - base_v, 0);
        check("t4_ready_after_eop", rx_ready, 1'b0);

        // 5: bus reset
        base_v = valid_cnt;
        for (int i = 0; i < 29; i++) hold(SE0);
        check("t5_bus_reset_early", bus_reset, 1'b0);
        hold(SE0);
        hold(SE0);
        check("t5_bus_reset_set", bus_reset, 1'b1);
        idle(3);
        check("t5_bus_reset_clear", bus_reset, 1'b0);
        check("t5_valid_count", valid_cnt - base_v, 0);
        idle(2);

        // 6a: jittered bit periods
        base_v = valid_cnt;
        base_e = err_cnt;
        jitter = 1'b1;
        jit_phase = 1'b0;
        send_sync();
        send_bits(8'hC3, 0, 7, 1'b1);
        send_eop();
        jitter = 1'b0;
        idle(4);
        check("t6_valid_count", valid_cnt - base_v, 1);
        check("t6_byte", bytes[base_v[5:0]], 8'hC3);
        check("t6_err_count", err_cnt - base_e, 0);

        // 6b: rx_en dropped mid-byte
        base_v = valid_cnt;
        base_e = err_cnt;
        jitter = 1'b1;
        jit_phase = 1'b0;
        send_sync();
        send_bits(8'hC3, 0, 3, 1'b1);
        check("t6b_ready_before", rx_ready, 1'b1);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("t6b_ready_dropped", rx_ready, 1'b0);
        send_bits(8'hC3, 4, 7, 1'b1);
        send_eop();
        jitter = 1'b0;
        idle(4);
        rx_en = 1'b1;
        idle(2);
        check("t6b_valid_count", valid_cnt - base_v, 0);
        check("t6b_err_count", err_cnt - base_e, 0);

        // 7: reset mid-packet
        base_v = valid_cnt;
        send_sync();
        send_bits(8'hA5, 0, 7, 1'b1);
        send_bits(8'h3C, 0, 2, 1'b1);
        check("t7_data_before_reset", rx_data, 8'hA5);
        rstn = 1'b0;
        #1;
        check("t7_data", rx_data, 8'h00);
        check("t7_valid", rx_valid, 1'b0);
        check("t7_ready", rx_ready, 1'b0);
        check("t7_err", rx_err, 1'b0);
        check("t7_bus_reset", bus_reset, 1'b0);
        send_bits(8'h3C, 3, 7, 1'b1);
        send_eop();
        idle(2);
        rstn = 1'b1;
        idle(4);
        check("t7_valid_count", valid_cnt - base_v, 1);

        check("valid_err_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
